// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: data bus width, register index
// width and the result-select encoding.
package wb_stage_pkg;

  localparam int DATA_BUS_SIZE = 64;
  typedef logic [DATA_BUS_SIZE-1:0] DATA_BUS;

  localparam int REG_IDX_W = 5;

  localparam logic WB_SEL_ALU = 1'b0;
  localparam logic WB_SEL_CSR = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Generic in-order FIFO with push/pop, occupancy count and an exposed entry
// array so the parent can search pending entries.
module wb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [CNT_W-1:0] count,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [W-1:0]     entries [DEPTH]
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is cleared on reset so a stale entry can never drive the write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count   = count_q;
  assign rd_ptr  = rd_ptr_q;
  assign entries = mem_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, x0 masking, in-order buffering, register-file
// write port and forwarding lookup. WB_DIFFTEST_EN adds the pc/inst commit sideband.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W = DATA_BUS_SIZE,
  parameter int DEPTH  = 2,
  parameter int IDX_W  = REG_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [IDX_W-1:0]  ex_rd_idx,
  input  logic              ex_rd_wen,
  input  logic              ex_res_sel,
  input  logic [DATA_W-1:0] ex_alu_res,
  input  logic [DATA_W-1:0] ex_csr_read,
  input  logic              wb_stall,
  output logic              rf_wen,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              retire,
`ifdef WB_DIFFTEST_EN
  input  logic [63:0]       ex_pc,
  input  logic [31:0]       ex_inst,
  output logic [63:0]       commit_pc,
  output logic [31:0]       commit_inst,
  output logic [63:0]       commit_cnt,
`endif
  input  logic [IDX_W-1:0]  fwd_rs1_idx,
  input  logic [IDX_W-1:0]  fwd_rs2_idx,
  output logic              fwd_rs1_hit,
  output logic              fwd_rs2_hit,
  output logic [DATA_W-1:0] fwd_rs1_data,
  output logic [DATA_W-1:0] fwd_rs2_data
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int ENT_CORE = IDX_W + 1 + DATA_W;
`ifdef WB_DIFFTEST_EN
  localparam int ENT_W    = ENT_CORE + 96;
`else
  localparam int ENT_W    = ENT_CORE;
`endif

  // Entry layout, LSB first: data, wen, rd_idx, [inst, pc].
  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  entries [DEPTH];
  logic [ENT_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] sel_data;
  logic              ent_wen;
  logic              push;
  logic              pop;

  assign sel_data = (ex_res_sel == WB_SEL_CSR) ? ex_csr_read : ex_alu_res;
  assign ent_wen  = ex_rd_wen && (ex_rd_idx != '0);
`ifdef WB_DIFFTEST_EN
  assign push_ent = {ex_pc, ex_inst, ex_rd_idx, ent_wen, sel_data};
`else
  assign push_ent = {ex_rd_idx, ent_wen, sel_data};
`endif

  assign ex_ready = rst && (count != CNT_W'(DEPTH));
  assign push     = ex_valid && ex_ready;
  assign pop      = (count != '0) && !wb_stall;

  wb_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push    (push),
    .pop     (pop),
    .wdata   (push_ent),
    .count   (count),
    .rd_ptr  (rd_ptr),
    .entries (entries)
  );

  assign head     = entries[rd_ptr];
  assign rf_wen   = pop && head[DATA_W];
  assign rf_waddr = head[DATA_W+1 +: IDX_W];
  assign rf_wdata = head[DATA_W-1:0];
  assign retire   = pop;

  // Walk from oldest to youngest so the youngest matching entry overrides.
  always_comb begin
    logic [PTR_W-1:0] slot;
    logic [ENT_W-1:0] ent;
    fwd_rs1_hit  = 1'b0;
    fwd_rs2_hit  = 1'b0;
    fwd_rs1_data = '0;
    fwd_rs2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr + PTR_W'(i);
      ent  = entries[slot];
      if ((CNT_W'(i) < count) && ent[DATA_W]) begin
        if ((fwd_rs1_idx != '0) && (ent[DATA_W+1 +: IDX_W] == fwd_rs1_idx)) begin
          fwd_rs1_hit  = 1'b1;
          fwd_rs1_data = ent[DATA_W-1:0];
        end
        if ((fwd_rs2_idx != '0) && (ent[DATA_W+1 +: IDX_W] == fwd_rs2_idx)) begin
          fwd_rs2_hit  = 1'b1;
          fwd_rs2_data = ent[DATA_W-1:0];
        end
      end
    end
  end

`ifdef WB_DIFFTEST_EN
  logic [63:0] commit_cnt_q, commit_cnt_d;

  always_comb begin
    commit_cnt_d = commit_cnt_q;
    if (pop) begin
      commit_cnt_d = commit_cnt_q + 64'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_cnt_q <= '0;
    end else begin
      commit_cnt_q <= commit_cnt_d;
    end
  end

  assign commit_pc   = head[ENT_CORE+32 +: 64];
  assign commit_inst = head[ENT_CORE +: 32];
  assign commit_cnt  = commit_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: driver pushes instructions and queues the
// expected write-port beat; a negedge monitor pops and compares on each retire.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int DATA_W = 64;
  localparam int IDX_W  = 5;
  localparam int EXP_W  = 1 + IDX_W + DATA_W;

  logic              clk;
  logic              rst;
  logic              ex_valid;
  logic              ex_ready;
  logic [IDX_W-1:0]  ex_rd_idx;
  logic              ex_rd_wen;
  logic              ex_res_sel;
  logic [DATA_W-1:0] ex_alu_res;
  logic [DATA_W-1:0] ex_csr_read;
  logic              wb_stall;
  logic              rf_wen;
  logic [IDX_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              retire;
  logic [IDX_W-1:0]  fwd_rs1_idx;
  logic [IDX_W-1:0]  fwd_rs2_idx;
  logic              fwd_rs1_hit;
  logic              fwd_rs2_hit;
  logic [DATA_W-1:0] fwd_rs1_data;
  logic [DATA_W-1:0] fwd_rs2_data;
`ifdef WB_DIFFTEST_EN
  logic [63:0]       ex_pc;
  logic [31:0]       ex_inst;
  logic [63:0]       commit_pc;
  logic [31:0]       commit_inst;
  logic [63:0]       commit_cnt;
`endif

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] exp_v;
  int n_vec      = 0;
  int n_err      = 0;
  int retire_cnt = 0;
  int stream_base;

  wb_stage #(.DATA_W(DATA_W), .DEPTH(2), .IDX_W(IDX_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_rd_idx    (ex_rd_idx),
    .ex_rd_wen    (ex_rd_wen),
    .ex_res_sel   (ex_res_sel),
    .ex_alu_res   (ex_alu_res),
    .ex_csr_read  (ex_csr_read),
    .wb_stall     (wb_stall),
    .rf_wen       (rf_wen),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .retire       (retire),
`ifdef WB_DIFFTEST_EN
    .ex_pc        (ex_pc),
    .ex_inst      (ex_inst),
    .commit_pc    (commit_pc),
    .commit_inst  (commit_inst),
    .commit_cnt   (commit_cnt),
`endif
    .fwd_rs1_idx  (fwd_rs1_idx),
    .fwd_rs2_idx  (fwd_rs2_idx),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Driver: present one instruction, wait (bounded) for acceptance.
  task automatic drive(input logic [IDX_W-1:0] rd, input logic wen, input logic sel,
                       input logic [63:0] alu, input logic [63:0] csr,
                       input logic exp_wen, input logic [63:0] exp_data, input bit track);
    int waited = 0;
    ex_valid    = 1'b1;
    ex_rd_idx   = rd;
    ex_rd_wen   = wen;
    ex_res_sel  = sel;
    ex_alu_res  = alu;
    ex_csr_read = csr;
`ifdef WB_DIFFTEST_EN
    ex_pc       = 64'h8000_0000 + 64'(rd);
    ex_inst     = 32'h0000_0013;
`endif
    @(negedge clk);
    while (!ex_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!ex_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: got ex_ready 0 for %0d cycles, expected 1", waited);
    end else if (track) begin
      exp_q.push_back({exp_wen, rd, exp_data});
    end
    @(posedge clk);
    #1;
    ex_valid = 1'b0;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && retire) begin
      retire_cnt++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_retire: got wen %0b waddr %0d wdata 0x%0h, expected no retire",
                 rf_wen, rf_waddr, rf_wdata);
      end else begin
        exp_v = exp_q.pop_front();
        if ({rf_wen, rf_waddr, rf_wdata} !== exp_v) begin
          n_err++;
          $display("FAIL writeback: got wen %0b waddr %0d wdata 0x%0h, expected wen %0b waddr %0d wdata 0x%0h",
                   rf_wen, rf_waddr, rf_wdata, exp_v[EXP_W-1], exp_v[DATA_W +: IDX_W], exp_v[DATA_W-1:0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_rd_idx = '0; ex_rd_wen = 1'b0; ex_res_sel = WB_SEL_ALU;
    ex_alu_res = '0; ex_csr_read = '0; wb_stall = 1'b0;
    fwd_rs1_idx = '0; fwd_rs2_idx = '0;
`ifdef WB_DIFFTEST_EN
    ex_pc = '0; ex_inst = '0;
`endif
    #2 rst = 1'b0;
    #10;
    check("reset_ex_ready", 64'(ex_ready), 64'd0);
    check("reset_rf_wen",   64'(rf_wen),   64'd0);
    check("reset_retire",   64'(retire),   64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("ready_after_reset", 64'(ex_ready), 64'd1);
    @(posedge clk); #1;

    // Single ALU push, one-cycle latency to the write port
    drive(5'd5, 1'b1, WB_SEL_ALU, 64'h1234, 64'h0, 1'b1, 64'h1234, 1'b1);
    @(negedge clk);
    check("first_retire", 64'(retire), 64'd1);
    check("first_rf_wen", 64'(rf_wen), 64'd1);
    @(negedge clk);
    check("empty_after_one", 64'(retire), 64'd0);
    @(posedge clk); #1;

    // CSR select, x0 masking, explicit no-write
    drive(5'd3, 1'b1, WB_SEL_CSR, 64'hFFFF, 64'hA0, 1'b1, 64'hA0, 1'b1);
    drive(5'd0, 1'b1, WB_SEL_ALU, 64'h55,   64'h0,  1'b0, 64'h55, 1'b1);
    drive(5'd9, 1'b0, WB_SEL_ALU, 64'h99,   64'h0,  1'b0, 64'h99, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Fill under stall, check backpressure and youngest-wins forwarding
    wb_stall = 1'b1;
    drive(5'd7, 1'b1, WB_SEL_ALU, 64'd1, 64'h0, 1'b1, 64'd1, 1'b1);
    drive(5'd7, 1'b1, WB_SEL_ALU, 64'd2, 64'h0, 1'b1, 64'd2, 1'b1);
    fwd_rs1_idx = 5'd7;
    fwd_rs2_idx = 5'd0;
    ex_valid = 1'b1; ex_rd_idx = 5'd9; ex_rd_wen = 1'b1; ex_res_sel = WB_SEL_ALU; ex_alu_res = 64'd3;
    exp_q.push_back({1'b1, 5'd9, 64'd3});
    @(negedge clk);
    check("full_not_ready", 64'(ex_ready),    64'd0);
    check("fwd_rs1_hit",    64'(fwd_rs1_hit), 64'd1);
    check("fwd_rs1_data",   fwd_rs1_data,     64'd2);
    check("fwd_rs2_x0_hit", 64'(fwd_rs2_hit), 64'd0);
    fwd_rs2_idx = 5'd9;
    #1;
    check("fwd_unaccepted", 64'(fwd_rs2_hit), 64'd0);
    @(posedge clk); #1;
    wb_stall = 1'b0;
    @(negedge clk);
    check("drain_retire0",    64'(retire),   64'd1);
    check("ready_low_on_pop", 64'(ex_ready), 64'd0);
    @(negedge clk);
    check("drain_retire1",  64'(retire),   64'd1);
    check("ready_returns",  64'(ex_ready), 64'd1);
    @(posedge clk); #1;
    ex_valid = 1'b0;
    @(negedge clk);
    check("drain_retire2", 64'(retire), 64'd1);
    @(posedge clk); #1;

    // Streaming: push and pop every cycle
    stream_base = retire_cnt;
    ex_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ex_rd_idx = 5'(10 + i); ex_rd_wen = 1'b1; ex_res_sel = WB_SEL_ALU; ex_alu_res = 64'(256 + i);
`ifdef WB_DIFFTEST_EN
      ex_pc = 64'h8000_1000 + 64'(4 * i);
`endif
      @(negedge clk);
      check("stream_ready", 64'(ex_ready), 64'd1);
      if (ex_ready) exp_q.push_back({1'b1, 5'(10 + i), 64'(256 + i)});
      @(posedge clk); #1;
    end
    ex_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("stream_retires", 64'(retire_cnt - stream_base), 64'd10);
`ifdef WB_DIFFTEST_EN
    check("commit_cnt", commit_cnt, 64'd17);
`endif

    // Asynchronous reset with two entries pending
    wb_stall = 1'b1;
    drive(5'd4, 1'b1, WB_SEL_ALU, 64'h44, 64'h0, 1'b1, 64'h44, 1'b0);
    drive(5'd6, 1'b1, WB_SEL_ALU, 64'h66, 64'h0, 1'b1, 64'h66, 1'b0);
    fwd_rs1_idx = 5'd4;
    fwd_rs2_idx = 5'd6;
    #1;
    check("pre_rst_rs1_data", fwd_rs1_data, 64'h44);
    check("pre_rst_rs2_hit",  64'(fwd_rs2_hit), 64'd1);
    wb_stall = 1'b0;
    #1;
    check("pre_rst_retire", 64'(retire), 64'd1);
    rst = 1'b0;
    #1;
    check("rst_rf_wen",   64'(rf_wen),      64'd0);
    check("rst_retire",   64'(retire),      64'd0);
    check("rst_rs1_hit",  64'(fwd_rs1_hit), 64'd0);
    check("rst_rs2_hit",  64'(fwd_rs2_hit), 64'd0);
    check("rst_rf_wdata", rf_wdata,         64'd0);
    check("rst_ex_ready", 64'(ex_ready),    64'd0);
    @(negedge clk);
    rst = 1'b1;
`ifdef WB_DIFFTEST_EN
    #1;
    check("commit_cnt_rst", commit_cnt, 64'd0);
`endif
    repeat (4) @(negedge clk);
    check("no_stale_retire", 64'(retire), 64'd0);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
